// File: rtl/dmem_pkg.sv
// Shared types and decode helpers for the data-memory access controller.
// Access-size (func3) encodings live here alongside the helpers that decode them.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {IDLE, RD_LO, RD_HI, WR_HI} dmem_state_t;

    function automatic logic [2:0] size_bytes(input logic [2:0] func3);
        case (func3)
            F3_B, F3_BU: return 3'd1;
            F3_H, F3_HU: return 3'd2;
            default:     return 3'd4;
        endcase
    endfunction

    function automatic logic [3:0] lane_mask(input logic [2:0] func3);
        case (size_bytes(func3))
            3'd1:    return 4'b0001;
            3'd2:    return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/load_align_ext.sv
// Load data aligner: shifts a two-word window by the byte offset and
// sign- or zero-extends the selected byte/half/word to 32 bits.
module load_align_ext
    import dmem_pkg::*;
(
    input  logic [63:0] window,
    input  logic [1:0]  offset,
    input  logic [2:0]  func3,
    output logic [31:0] data
);

    logic [31:0] sel;

    always_comb begin
        sel = 32'(window >> {offset, 3'b000});
        case (func3)
            F3_B:    data = {{24{sel[7]}}, sel[7:0]};
            F3_BU:   data = {24'b0, sel[7:0]};
            F3_H:    data = {{16{sel[15]}}, sel[15:0]};
            F3_HU:   data = {16'b0, sel[15:0]};
            F3_W:    data = sel;
            default: data = sel;
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Load/store sequencer between the MEM stage and a byte-enabled synchronous RAM.
// Define DMEM_MISALIGNED_SPLIT_EN to split misaligned accesses into two RAM words.
module dmem_access_ctrl
    import dmem_pkg::*;
#(
    parameter  int unsigned MEM_WORDS = 64,
    localparam int unsigned AW        = $clog2(MEM_WORDS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          MemRead,
    input  logic          MemWrite,
    input  logic [2:0]    func3,
    input  logic [31:0]   addr,
    input  logic [31:0]   w_data,
    output logic [31:0]   r_data,
    output logic          r_valid,
    output logic          stall,
    output logic          access_fault,
    output logic          ram_en,
    output logic [3:0]    ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [31:0]   ram_wdata,
    input  logic [31:0]   ram_rdata
);

    dmem_state_t   state_q, state_d;
    logic [31:0]   hold_q, hold_d;
    logic [AW-1:0] addr_a, addr_hi;
    logic [7:0]    we_mask8;
    logic [63:0]   wdata64;
    logic [63:0]   window;
    logic [31:0]   ext_data;
    logic          misaligned;
    logic          req_illegal;
    logic          unused_addr_bits;

    // Address, lane and misalignment decode shared by all states.
    assign addr_a     = addr[AW+1:2];
    assign addr_hi    = addr_a + AW'(1);
    assign we_mask8   = 8'(lane_mask(func3)) << addr[1:0];
    assign wdata64    = 64'(w_data) << {addr[1:0], 3'b000};
    assign misaligned = ({1'b0, addr[1:0]} + size_bytes(func3)) > 3'd4;

    assign unused_addr_bits = ^addr[31:AW+2];

`ifndef DMEM_MISALIGNED_SPLIT_EN
    logic unused_split;
    assign unused_split = ^{we_mask8[7:4], wdata64[63:32], addr_hi};
`endif

    always_comb begin
        req_illegal = (MemRead && MemWrite)
                   || (MemRead  && !(func3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU}))
                   || (MemWrite && !(func3 inside {F3_B, F3_H, F3_W}));
`ifndef DMEM_MISALIGNED_SPLIT_EN
        req_illegal = req_illegal || ((MemRead || MemWrite) && misaligned);
`endif
    end

    // Second word of a split load sits above the held first word.
    assign window = (state_q == RD_HI) ? {ram_rdata, hold_q} : {32'b0, ram_rdata};

    load_align_ext u_align (
        .window (window),
        .offset (addr[1:0]),
        .func3  (func3),
        .data   (ext_data)
    );

    assign r_data = r_valid ? ext_data : 32'b0;

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        stall        = 1'b0;
        r_valid      = 1'b0;
        access_fault = 1'b0;
        ram_en       = 1'b0;
        ram_we       = 4'b0;
        ram_addr     = addr_a;
        ram_wdata    = wdata64[31:0];

        case (state_q)
            IDLE: begin
                if (req_illegal) begin
                    access_fault = 1'b1;
                end else if (MemWrite) begin
                    ram_en = 1'b1;
                    ram_we = we_mask8[3:0];
`ifdef DMEM_MISALIGNED_SPLIT_EN
                    if (misaligned) begin
                        stall   = 1'b1;
                        state_d = WR_HI;
                    end
`endif
                end else if (MemRead) begin
                    ram_en  = 1'b1;
                    stall   = 1'b1;
                    state_d = RD_LO;
                end
            end
            RD_LO: begin
`ifdef DMEM_MISALIGNED_SPLIT_EN
                if (misaligned) begin
                    hold_d   = ram_rdata;
                    ram_en   = 1'b1;
                    ram_addr = addr_hi;
                    stall    = 1'b1;
                    state_d  = RD_HI;
                end else
`endif
                begin
                    r_valid = 1'b1;
                    state_d = IDLE;
                end
            end
`ifdef DMEM_MISALIGNED_SPLIT_EN
            RD_HI: begin
                r_valid = 1'b1;
                state_d = IDLE;
            end
            WR_HI: begin
                ram_en    = 1'b1;
                ram_addr  = addr_hi;
                ram_we    = we_mask8[7:4];
                ram_wdata = wdata64[63:32];
                state_d   = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase

        // Reset silences every output regardless of the request.
        if (reset) begin
            stall        = 1'b0;
            r_valid      = 1'b0;
            access_fault = 1'b0;
            ram_en       = 1'b0;
            ram_we       = 4'b0;
            ram_addr     = '0;
            ram_wdata    = 32'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            hold_q  <= 32'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

endmodule
